// File: rtl/wb_scomp_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_scomp_pkg
//   Shared types and helpers for the Wishbone-to-SCOMP I/O bridge.
//   - sc_state_e : bridge FSM state encoding
//   - sc_extend  : sign/zero extension of SCOMP read data to 32 bits
//   - sc_legal   : request legality (address range, write byte lanes)
// -----------------------------------------------------------------------------
package wb_scomp_pkg;

  localparam int WB_ADDR_W = 30;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_ACK    = 3'd2,
    ST_ERR    = 3'd3,
    ST_GAP    = 3'd4
  } sc_state_e;

  // Keeps the low w bits of d; the remaining bits are copies of bit w-1
  // when sext is set, zeros otherwise.
  function automatic logic [31:0] sc_extend(input logic [31:0] d,
                                            input int          w,
                                            input logic        sext);
    logic [31:0] keep;
    logic [4:0]  msb;
    logic        sign;
    keep = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb  = 5'(w - 1);
    sign = sext & d[msb];
    return (d & keep) | (sign ? ~keep : 32'd0);
  endfunction

  // A request is legal when no address bit above the SCOMP address field is
  // set and, for writes, every byte lane covering the SCOMP data word is
  // enabled (partial writes cannot be expressed on the SCOMP bus).
  function automatic logic sc_legal(input logic [29:0] addr,
                                    input logic        we,
                                    input logic [3:0]  sel,
                                    input int          addr_w,
                                    input int          data_w);
    logic [31:0] hi;
    logic [4:0]  need;
    hi   = {2'b00, addr} >> addr_w;
    need = (5'd1 << (data_w / 8)) - 5'd1;
    return (hi == 32'd0) && !(we && (({1'b0, sel} & need) != need));
  endfunction

endpackage

// File: rtl/wb_scomp_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_scomp_bridge_if
//   Pipelined 32-bit Wishbone slave-side bundle used by the SCOMP bridge.
//   master : drives cyc/stb/we/addr/wdata/sel, receives ack/err/stall/rdata
//   slave  : the reverse
//   Signals
//     cyc, stb, we     cycle, strobe, write enable
//     addr   [29:0]    word address
//     wdata  [31:0]    write data
//     sel    [3:0]     byte lanes
//     ack, err         one-cycle completion / error completion
//     stall            request not accepted this cycle
//     rdata  [31:0]    read data, valid with ack
// -----------------------------------------------------------------------------
interface wb_scomp_bridge_if;
  import wb_scomp_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] wdata;
  logic [WB_SEL_W-1:0]  sel;
  logic                 ack;
  logic                 err;
  logic                 stall;
  logic [WB_DATA_W-1:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  ack, err, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output ack, err, stall, rdata
  );

endinterface

// File: rtl/wb_scomp_bridge_clk_div.sv
// -----------------------------------------------------------------------------
// sc_clk_div
//   Generates the SCOMP bus clock from i_clk. The counter runs CLK_DIV-1..0
//   and o_sc_clk toggles whenever it reaches 0, so one SCOMP period is
//   2*CLK_DIV system cycles. The ticks are combinational and mark the cycle
//   whose closing i_clk edge makes o_sc_clk rise (o_rise_tick) or fall
//   (o_fall_tick), letting the bridge update bus signals on that same edge.
//   Ports
//     i_clk, i_reset_n   system clock, async active-low reset
//     o_sc_clk           divided SCOMP clock
//     o_rise_tick        next i_clk edge raises o_sc_clk
//     o_fall_tick        next i_clk edge lowers o_sc_clk
// -----------------------------------------------------------------------------
module sc_clk_div #(
  parameter int CLK_DIV = 6
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_sc_clk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          at_zero;

  assign at_zero     = (cnt_q == '0);
  assign o_rise_tick = at_zero && !o_sc_clk;
  assign o_fall_tick = at_zero &&  o_sc_clk;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      o_sc_clk <= 1'b0;
    end else if (at_zero) begin
      cnt_q    <= RELOAD;
      o_sc_clk <= ~o_sc_clk;
    end else begin
      cnt_q    <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/wb_scomp_bridge.sv
// -----------------------------------------------------------------------------
// wb_scomp_bridge
//   Translates single pipelined Wishbone requests into SCOMP I/O bus cycles.
//   One request is outstanding at a time; each SCOMP cycle opens on a rising
//   o_sc_clk edge and closes on a later rising edge, optionally stretched by
//   the device through i_sc_iowait up to MAX_WAIT extra periods.
//   Parameters
//     CLK_DIV    i_clk cycles per o_sc_clk half-period (>=2)
//     SC_ADDR_W  SCOMP I/O address width (1..30)
//     SC_DATA_W  SCOMP data width (8,16,24,32)
//     MAX_WAIT   extra SCOMP periods tolerated before timeout (0..15)
//     READ_SEXT  1: sign-extend read data, 0: zero-extend
//   Ports
//     i_clk, i_reset_n  system clock, async active-low reset
//     wb                Wishbone slave bundle (cyc/stb/we/addr/wdata/sel in,
//                       ack/err/stall/rdata out)
//     o_sc_clk          divided SCOMP clock
//     o_sc_iocyc        SCOMP I/O cycle active
//     o_sc_iowr         SCOMP write strobe, only while o_sc_iocyc
//     o_sc_ioaddr       SCOMP I/O address, 0 when idle
//     io_sc_iodata      SCOMP data, driven only during a write cycle
//     i_sc_iowait       device asks for one more SCOMP period
// -----------------------------------------------------------------------------
module wb_scomp_bridge
  import wb_scomp_pkg::*;
#(
  parameter int CLK_DIV   = 6,
  parameter int SC_ADDR_W = 8,
  parameter int SC_DATA_W = 16,
  parameter int MAX_WAIT  = 4,
  parameter int READ_SEXT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  wb_scomp_bridge_if.slave     wb,
  output logic                 o_sc_clk,
  output logic                 o_sc_iocyc,
  output logic                 o_sc_iowr,
  output logic [SC_ADDR_W-1:0] o_sc_ioaddr,
  inout  wire  [SC_DATA_W-1:0] io_sc_iodata,
  input  logic                 i_sc_iowait
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_ACTIVE = 3'(ST_ACTIVE);
  localparam logic [2:0] S_ACK    = 3'(ST_ACK);
  localparam logic [2:0] S_ERR    = 3'(ST_ERR);
  localparam logic [2:0] S_GAP    = 3'(ST_GAP);

  localparam logic [3:0] MAX_W    = 4'(MAX_WAIT);
  localparam logic       SEXT     = (READ_SEXT != 0);

  logic                 rise_tick;
  logic                 fall_tick;

  logic [2:0]           state_q;
  logic                 iocyc_q;
  logic                 iowr_q;
  logic [SC_ADDR_W-1:0] ioaddr_q;
  logic [SC_DATA_W-1:0] wdata_q;
  logic [3:0]           waits_q;
  logic                 cyc_lost_q;
  logic                 ack_q;
  logic                 err_q;
  logic [31:0]          rdata_q;

  logic                 stall;
  logic                 accept;
  logic                 legal;
  logic                 live;
  logic [31:0]          rd_raw;
  logic [31:0]          rd_ext;
  logic                 unused_wdata;

  sc_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .o_sc_clk    (o_sc_clk),
    .o_rise_tick (rise_tick),
    .o_fall_tick (fall_tick)
  );

  // Requests are only taken on the cycle before o_sc_clk rises, so the
  // SCOMP cycle always starts aligned with a rising SCOMP clock edge.
  assign stall  = !(state_q == S_IDLE && rise_tick);
  assign accept = wb.cyc && wb.stb && !stall;
  assign legal  = sc_legal(wb.addr, wb.we, wb.sel, SC_ADDR_W, SC_DATA_W);

  // The master may abandon the cycle; the SCOMP side still finishes cleanly
  // but no completion is reported back.
  assign live   = wb.cyc && !cyc_lost_q;

  always_comb begin
    rd_raw                  = '0;
    rd_raw[SC_DATA_W-1:0]   = io_sc_iodata;
    rd_ext                  = sc_extend(rd_raw, SC_DATA_W, SEXT);
  end

  // Only the low SC_DATA_W bits of the write word reach the SCOMP bus.
  assign unused_wdata = ^wb.wdata;

  // Request capture: write data for the SCOMP data phase
  always_ff @(posedge i_clk) begin
    if (accept) begin
      wdata_q <= wb.wdata[SC_DATA_W-1:0];
    end
  end

  // Bus-cycle control and Wishbone completion
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      iocyc_q    <= 1'b0;
      iowr_q     <= 1'b0;
      ioaddr_q   <= '0;
      waits_q    <= '0;
      cyc_lost_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            waits_q    <= '0;
            cyc_lost_q <= 1'b0;
            if (legal) begin
              iocyc_q  <= 1'b1;
              iowr_q   <= wb.we;
              ioaddr_q <= wb.addr[SC_ADDR_W-1:0];
              state_q  <= S_ACTIVE;
            end else begin
              err_q    <= 1'b1;
              state_q  <= S_ERR;
            end
          end
        end

        S_ACTIVE: begin
          if (!wb.cyc) begin
            cyc_lost_q <= 1'b1;
          end
          if (rise_tick) begin
            if (i_sc_iowait && (waits_q < MAX_W)) begin
              waits_q <= waits_q + 1'b1;
            end else begin
              iocyc_q  <= 1'b0;
              iowr_q   <= 1'b0;
              ioaddr_q <= '0;
              if (i_sc_iowait) begin
                // device still busy after the last allowed wait period
                err_q   <= live;
                state_q <= S_ERR;
              end else begin
                ack_q   <= live;
                if (live && !iowr_q) begin
                  rdata_q <= rd_ext;
                end
                state_q <= S_ACK;
              end
            end
          end
        end

        S_ACK: begin
          rdata_q <= '0;
          state_q <= S_GAP;
        end

        S_ERR: begin
          state_q <= S_GAP;
        end

        // Hold off the next request until o_sc_clk has fallen, so iocyc stays
        // low for at least one SCOMP half-period between cycles.
        S_GAP: begin
          if (fall_tick) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.stall = stall;
  assign wb.rdata = rdata_q;

  assign o_sc_iocyc   = iocyc_q;
  assign o_sc_iowr    = iowr_q;
  assign o_sc_ioaddr  = ioaddr_q;
  assign io_sc_iodata = (iocyc_q && iowr_q) ? wdata_q : {SC_DATA_W{1'bz}};

endmodule

// File: tb/tb_wb_scomp_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_scomp_bridge
//   Directed bench for wb_scomp_bridge. Two instances share the Wishbone
//   stimulus: dut (zero-extending reads, SCOMP device returns dev_val) and
//   dut_s (sign-extending reads, device always returns 0xBEEF). Expected
//   completions of dut are queued when a request is accepted and popped by a
//   monitor when ack/err appears.
// -----------------------------------------------------------------------------
module tb_wb_scomp_bridge;

  localparam int CLK_DIV = 6;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        iowait;
  logic [15:0] dev_val;
  int          sc_rises;
  int          wait_until;

  int          checks;
  int          errors;
  int          ncnt;
  exp_t        sb[$];
  exp_t        mon_e;
  int          acc_a, acc_b;

  wire         sc_clk0, iocyc0, iowr0;
  wire  [7:0]  ioaddr0;
  wire  [15:0] bus0;
  wire         sc_clk1, iocyc1, iowr1;
  wire  [7:0]  ioaddr1;
  wire  [15:0] bus1;

  wb_scomp_bridge_if wb0();
  wb_scomp_bridge_if wb1();

  assign wb0.cyc   = cyc;
  assign wb0.stb   = stb;
  assign wb0.we    = we;
  assign wb0.addr  = addr;
  assign wb0.wdata = wdat;
  assign wb0.sel   = sel;
  assign wb1.cyc   = cyc;
  assign wb1.stb   = stb;
  assign wb1.we    = we;
  assign wb1.addr  = addr;
  assign wb1.wdata = wdat;
  assign wb1.sel   = sel;

  // SCOMP devices: drive the bus during read cycles only
  assign bus0   = (iocyc0 && !iowr0) ? dev_val  : 16'hzzzz;
  assign bus1   = (iocyc1 && !iowr1) ? 16'hBEEF : 16'hzzzz;
  assign iowait = (sc_rises < wait_until);

  wb_scomp_bridge #(
    .CLK_DIV(CLK_DIV), .SC_ADDR_W(8), .SC_DATA_W(16), .MAX_WAIT(4), .READ_SEXT(0)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .wb(wb0),
    .o_sc_clk(sc_clk0), .o_sc_iocyc(iocyc0), .o_sc_iowr(iowr0),
    .o_sc_ioaddr(ioaddr0), .io_sc_iodata(bus0), .i_sc_iowait(iowait)
  );

  wb_scomp_bridge #(
    .CLK_DIV(CLK_DIV), .SC_ADDR_W(8), .SC_DATA_W(16), .MAX_WAIT(4), .READ_SEXT(1)
  ) dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .wb(wb1),
    .o_sc_clk(sc_clk1), .o_sc_iocyc(iocyc1), .o_sc_iowr(iowr1),
    .o_sc_ioaddr(ioaddr1), .io_sc_iodata(bus1), .i_sc_iowait(iowait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    sc_rises = 0;
    forever begin
      @(posedge sc_clk0);
      sc_rises++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor for dut: scoreboard pop on every completion, idle data, iocyc gap
  initial begin
    bit seen;
    int low_run;
    ncnt = 0;
    seen = 0;
    low_run = 0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (wb0.ack || wb0.err) begin
        chk("ack_err_exclusive", {31'b0, wb0.ack && wb0.err}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: ack=%0b err=%0b, expected no response (t=%0t)",
                   wb0.ack, wb0.err, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_is_err", {31'b0, wb0.err}, {31'b0, mon_e.is_err});
          chk("resp_data", wb0.rdata, mon_e.data);
          chk("resp_cycle", ncnt, mon_e.at);
        end
      end else begin
        chk("rdata_idle_zero", wb0.rdata, 32'd0);
      end
      if (!rst_n) begin
        seen = 0;
        low_run = 0;
      end else if (iocyc0) begin
        if (seen && low_run > 0) begin
          checks++;
          if (low_run < CLK_DIV) begin
            errors++;
            $display("FAIL iocyc_gap: low for %0d cycles, expected >= %0d", low_run, CLK_DIV);
          end
        end
        seen = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  // Monitor for dut_s: reads extend 0xBEEF with sign, writes return 0
  initial begin
    logic wr1;
    wr1 = 1'b0;
    forever begin
      @(negedge clk);
      if (iocyc1) wr1 = iowr1;
      if (wb1.ack) chk("sext_data", wb1.rdata, wr1 ? 32'd0 : 32'hFFFF_BEEF);
    end
  end

  task automatic issue(input logic w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_err, input logic [31:0] exp_d,
                       input int lat, input logic push, input logic hold, input int nwait,
                       output int acc);
    bit   got;
    exp_t e;
    got = 0;
    acc = -1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (!wb0.stall) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: stall=1 after 200 cycles, expected 0");
      stb = 1'b0;
      return;
    end
    acc = ncnt;
    if (push) begin
      e.is_err = exp_err;
      e.data   = exp_d;
      e.at     = ncnt + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    wait_until = sc_rises + nwait;
    chk("stall_busy", {31'b0, wb0.stall}, 32'd1);
    if (!hold) stb = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) ok = 1;
    end
    chk("resp_arrived", {31'b0, ok}, 32'd1);
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
    dev_val = 16'h0000; wait_until = 0;

    // reset state
    #3;
    chk("rst_ack", {31'b0, wb0.ack}, 0);
    chk("rst_err", {31'b0, wb0.err}, 0);
    chk("rst_stall", {31'b0, wb0.stall}, 0);
    chk("rst_rdata", wb0.rdata, 0);
    chk("rst_sc_clk", {31'b0, sc_clk0}, 0);
    chk("rst_iocyc", {31'b0, iocyc0}, 0);
    chk("rst_iowr", {31'b0, iowr0}, 0);
    chk("rst_ioaddr", {24'b0, ioaddr0}, 0);
    #20 rst_n = 1'b1;
    idle(3);

    // plain read
    dev_val = 16'hBEEF;
    issue(1'b0, 30'h12, 32'h0, 4'hF, 1'b0, 32'h0000_BEEF, 13, 1'b1, 1'b0, 0, acc_a);
    chk("rd_iocyc", {31'b0, iocyc0}, 1);
    chk("rd_iowr", {31'b0, iowr0}, 0);
    chk("rd_ioaddr", {24'b0, ioaddr0}, 32'h12);
    wait_done();
    chk("rd_iocyc_after", {31'b0, iocyc0}, 0);

    // read with MSB set stays zero-extended
    dev_val = 16'h8001;
    issue(1'b0, 30'h7F, 32'h0, 4'hF, 1'b0, 32'h0000_8001, 13, 1'b1, 1'b0, 0, acc_a);
    wait_done();

    // write: bus carries low half only while iocyc
    issue(1'b1, 30'h05, 32'h1234_ABCD, 4'b0011, 1'b0, 32'h0, 13, 1'b1, 1'b0, 0, acc_a);
    chk("wr_iowr", {31'b0, iowr0}, 1);
    chk("wr_ioaddr", {24'b0, ioaddr0}, 32'h05);
    chk("wr_bus", {16'b0, bus0}, 32'h0000_ABCD);
    wait_done();
    chk("wr_iocyc_after", {31'b0, iocyc0}, 0);
    chk("wr_bus_released", {31'b0, bus0 !== 16'hABCD}, 1);

    // two wait periods
    dev_val = 16'h0042;
    issue(1'b0, 30'h20, 32'h0, 4'hF, 1'b0, 32'h0000_0042, 37, 1'b1, 1'b0, 2, acc_a);
    wait_done();

    // wait held past MAX_WAIT: timeout error
    issue(1'b0, 30'h21, 32'h0, 4'hF, 1'b1, 32'h0, 61, 1'b1, 1'b0, 5, acc_a);
    wait_done();
    chk("tmo_iocyc_low", {31'b0, iocyc0}, 0);

    // illegal address
    issue(1'b0, 30'h100, 32'h0, 4'hF, 1'b1, 32'h0, 1, 1'b1, 1'b0, 0, acc_a);
    chk("badaddr_no_iocyc", {31'b0, iocyc0}, 0);
    wait_done();
    chk("badaddr_no_iocyc_late", {31'b0, iocyc0}, 0);

    // illegal write byte lanes
    issue(1'b1, 30'h03, 32'h0000_1111, 4'b0001, 1'b1, 32'h0, 1, 1'b1, 1'b0, 0, acc_a);
    chk("badsel_no_iocyc", {31'b0, iocyc0}, 0);
    wait_done();

    // back-to-back with strobe held
    dev_val = 16'h0101;
    issue(1'b0, 30'h01, 32'h0, 4'hF, 1'b0, 32'h0000_0101, 13, 1'b1, 1'b1, 0, acc_a);
    issue(1'b0, 30'h02, 32'h0, 4'hF, 1'b0, 32'h0000_0101, 13, 1'b1, 1'b0, 0, acc_b);
    wait_done();
    chk("b2b_spacing", acc_b - acc_a, 32'd24);

    // cycle abandoned by master: SCOMP side finishes, no ack
    issue(1'b0, 30'h30, 32'h0, 4'hF, 1'b0, 32'h0, 13, 1'b0, 1'b0, 0, acc_a);
    idle(2);
    cyc = 1'b0; stb = 1'b0;
    idle(20);
    chk("drop_iocyc_low", {31'b0, iocyc0}, 0);

    // reset during an active write
    issue(1'b1, 30'h33, 32'h0000_5555, 4'hF, 1'b0, 32'h0, 13, 1'b0, 1'b0, 0, acc_a);
    idle(3);
    chk("prerst_bus", {16'b0, bus0}, 32'h0000_5555);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_iocyc", {31'b0, iocyc0}, 0);
    chk("midrst_iowr", {31'b0, iowr0}, 0);
    chk("midrst_ioaddr", {24'b0, ioaddr0}, 0);
    chk("midrst_sc_clk", {31'b0, sc_clk0}, 0);
    chk("midrst_bus_released", {31'b0, bus0 !== 16'h5555}, 1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;

    // read after reset
    dev_val = 16'h1357;
    issue(1'b0, 30'h12, 32'h0, 4'hF, 1'b0, 32'h0000_1357, 13, 1'b1, 1'b0, 0, acc_a);
    wait_done();

    idle(30);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
